// File: rtl/expr_bist_pkg.sv
// Shared constants, FSM encoding and LFSR/MISR step functions for the expression BIST sequencer.
package expr_bist_pkg;

    localparam int unsigned OPND_W      = 60;
    localparam int unsigned RES_W       = 90;
    localparam int unsigned LFSR_TAP_HI = 59;
    localparam int unsigned LFSR_TAP_LO = 58;

    localparam logic [RES_W-1:0] MISR_POLY = RES_W'(3) | (RES_W'(1) << 87);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Fibonacci LFSR step: shift left, feedback from the two top taps into bit 0
    function automatic logic [OPND_W-1:0] lfsr_next(input logic [OPND_W-1:0] l);
        return {l[OPND_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

    // Galois MISR step absorbing one result word
    function automatic logic [RES_W-1:0] misr_next(input logic [RES_W-1:0] m,
                                                    input logic [RES_W-1:0] d);
        return {m[RES_W-2:0], 1'b0} ^ (m[RES_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

endpackage

// File: rtl/expr_bist_misr.sv
// 90-bit signature register: clears on clr, absorbs din when en.
module expr_bist_misr
    import expr_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [RES_W-1:0] din,
    output logic [RES_W-1:0] sig
);

    // Signature register; clear wins over absorb
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule

// File: rtl/expr_bist_sched.sv
// BIST sequencer for one expression datapath: LFSR stimulus, MISR compaction, signature check.
// Optional mismatch counter/first-bad-index tracking when EXPR_BIST_MISMATCH_CNT_EN is defined.
module expr_bist_sched
    import expr_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned LAT         = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [OPND_W-1:0]                   seed_in,
    input  logic [RES_W-1:0]                    expected_sig,
    output logic [OPND_W-1:0]                   opnd,
    input  logic [RES_W-1:0]                    res_in,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [RES_W-1:0]                    signature,
`ifdef EXPR_BIST_MISMATCH_CNT_EN
    input  logic [RES_W-1:0]                    gold_in,
    output logic [15:0]                         mis_cnt,
    output logic [$clog2(NUM_VECTORS)-1:0]      first_bad,
`endif
    output logic [$clog2(NUM_VECTORS+1)-1:0]    vec_cnt
);

    localparam int unsigned CW = $clog2(NUM_VECTORS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECTORS - 1);

    state_t            state, state_nx;
    logic [OPND_W-1:0] lfsr, lfsr_d, opnd_d, seed_fix;
    logic [CW-1:0]     vec_cnt_d;
    logic              busy_d, done_d, pass_d;
    logic              accept, issue, last_issue, absorb, drain_last, misr_clr, sig_ok;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign issue      = (state == RUN);
    assign last_issue = issue && (vec_cnt == LAST_IDX);
    assign seed_fix   = (seed_in == '0) ? OPND_W'(1) : seed_in;

    // Valid pipe tracking in-flight vectors through the datapath
    if (LAT == 0) begin : g_nopipe
        assign absorb     = issue;
        assign drain_last = 1'b1;
    end else begin : g_pipe
        localparam logic [LAT-1:0] TOP_BIT = LAT'(1) << (LAT - 1);
        logic [LAT-1:0] vpipe;

        // Shift issue flags toward the result side
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vpipe <= '0;
            end else begin
                vpipe <= LAT'({vpipe, issue});
            end
        end

        assign absorb     = vpipe[LAT-1];
        assign drain_last = ((vpipe & ~TOP_BIT) == '0);
    end

    expr_bist_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (absorb),
        .din (res_in),
        .sig (signature)
    );

`ifdef EXPR_BIST_MISMATCH_CNT_EN
    localparam int unsigned IDX_W = $clog2(NUM_VECTORS);
    logic [IDX_W-1:0] abs_idx;

    // Per-result comparison against golden data; remember first failing index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_cnt   <= '0;
            first_bad <= '0;
            abs_idx   <= '0;
        end else if (accept) begin
            mis_cnt   <= '0;
            first_bad <= '0;
            abs_idx   <= '0;
        end else if (absorb) begin
            abs_idx <= abs_idx + IDX_W'(1);
            if (res_in != gold_in) begin
                if (mis_cnt == '0) first_bad <= abs_idx;
                if (mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
            end
        end
    end

    assign sig_ok = (signature == expected_sig) && (mis_cnt == '0);
`else
    assign sig_ok = (signature == expected_sig);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (last_issue) state_nx = (LAT == 0) ? CHECK : DRAIN;
            DRAIN:      if (drain_last) state_nx = CHECK;
            CHECK:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and LFSR
    always_comb begin
        lfsr_d    = lfsr;
        opnd_d    = '0;
        vec_cnt_d = vec_cnt;
        pass_d    = pass;
        misr_clr  = 1'b0;
        if (accept) begin
            lfsr_d    = seed_fix;
            opnd_d    = seed_fix;
            vec_cnt_d = '0;
            pass_d    = 1'b0;
            misr_clr  = 1'b1;
        end else if (issue) begin
            lfsr_d    = lfsr_next(lfsr);
            opnd_d    = last_issue ? '0 : lfsr_next(lfsr);
            vec_cnt_d = vec_cnt + CW'(1);
        end
        if (state == CHECK) pass_d = sig_ok;
        busy_d = (state_nx == RUN) || (state_nx == DRAIN) || (state_nx == CHECK);
        done_d = (state_nx == DONE);
    end

    // Output and LFSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= OPND_W'(1);
            opnd    <= '0;
            vec_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            lfsr    <= lfsr_d;
            opnd    <= opnd_d;
            vec_cnt <= vec_cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
        end
    end

endmodule

// File: tb/tb_expr_bist_sched.sv
// Self-checking bench for expr_bist_sched: one LAT=0 instance (3 vectors) and one LAT=2 instance (5 vectors).
module tb_expr_bist_sched;

    localparam int NV0 = 3;
    localparam int NV1 = 5;
    localparam logic [89:0] POLY = (90'h1 << 87) | 90'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [59:0] seed_in;
    logic [89:0] exp0, exp1;
    logic [59:0] opnd0, opnd1;
    logic [89:0] res0, res1, sig0, sig1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [1:0]  vc0;
    logic [2:0]  vc1;
    logic [59:0] d1 = '0, d2 = '0;
    int          dp_k;
`ifdef EXPR_BIST_MISMATCH_CNT_EN
    logic [89:0] gold0, gold1;
    logic [15:0] mc0, mc1;
    logic [1:0]  fb0;
    logic [2:0]  fb1;
    int          bad0, bad1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [59:0] m_ops  [0:4];
    logic [89:0] m_part [0:5];

    always #5 clk = ~clk;

    // Stand-in datapath: widened operand mixed with a shifted copy of itself
    function automatic logic [89:0] dp(input logic [59:0] x, input int k);
        logic [89:0] w;
        w = {30'b0, x};
        if (k == 0) return w;
        return w ^ (w << k);
    endfunction

    assign res0 = dp(opnd0, dp_k);
    assign res1 = dp(d2, dp_k);

    // Two-stage datapath pipeline for the LAT=2 instance
    always @(posedge clk) begin
        d1 <= opnd1;
        d2 <= d1;
    end

    expr_bist_sched #(.NUM_VECTORS(NV0), .LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .expected_sig(exp0),
        .opnd(opnd0), .res_in(res0), .busy(busy0), .done(done0), .pass(pass0),
        .signature(sig0),
`ifdef EXPR_BIST_MISMATCH_CNT_EN
        .gold_in(gold0), .mis_cnt(mc0), .first_bad(fb0),
`endif
        .vec_cnt(vc0)
    );

    expr_bist_sched #(.NUM_VECTORS(NV1), .LAT(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .expected_sig(exp1),
        .opnd(opnd1), .res_in(res1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1),
`ifdef EXPR_BIST_MISMATCH_CNT_EN
        .gold_in(gold1), .mis_cnt(mc1), .first_bad(fb1),
`endif
        .vec_cnt(vc1)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Reference: operand sequence and running signature after each absorbed result
    task automatic build_model(input logic [59:0] seed, input int k);
        logic [59:0] l;
        logic [89:0] m;
        l = (seed == '0) ? 60'd1 : seed;
        m = '0;
        m_part[0] = m;
        for (int i = 0; i < 5; i++) begin
            m_ops[i] = l;
            m = (m << 1) ^ (m[89] ? POLY : 90'd0) ^ dp(l, k);
            m_part[i+1] = m;
            l = {l[58:0], l[59] ^ l[58]};
        end
    endtask

    task automatic run(input logic [59:0] seed, input int k, input bit pulse_mid,
                       input bit bad_exp0, input bit bad_exp1);
        int  at0, at1;
        bit  ep0, ep1;
        dp_k = k;
        build_model(seed, k);
        ep0 = !bad_exp0;
        ep1 = !bad_exp1;
`ifdef EXPR_BIST_MISMATCH_CNT_EN
        ep0 = ep0 && (bad0 >= NV0);
        ep1 = ep1 && (bad1 >= NV1);
`endif
        @(negedge clk);
        seed_in = seed;
        exp0 = bad_exp0 ? (m_part[NV0] ^ (90'd1 << $urandom_range(89))) : m_part[NV0];
        exp1 = bad_exp1 ? (m_part[NV1] ^ (90'd1 << $urandom_range(89))) : m_part[NV1];
        start = 1'b1;
        at0 = 0;
        at1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = pulse_mid && (c == 2);
`ifdef EXPR_BIST_MISMATCH_CNT_EN
            gold0 = res0 ^ ((c - 1 == bad0) ? 90'd1 : 90'd0);
            gold1 = res1 ^ ((c - 3 == bad1) ? 90'd1 : 90'd0);
`endif
            if (c == 1) begin
                check("busy0_start", 96'(busy0), 96'(1));
                check("done0_drop", 96'(done0), 96'(0));
                check("busy1_start", 96'(busy1), 96'(1));
            end
            if (c <= NV0)     check("opnd0", 96'(opnd0), 96'(m_ops[c-1]));
            if (c == NV0 + 1) check("opnd0_idle", 96'(opnd0), 96'(0));
            if (c <= NV1)     check("opnd1", 96'(opnd1), 96'(m_ops[c-1]));
            if (c == NV1 + 1) check("opnd1_drain", 96'(opnd1), 96'(0));
            if (c <= NV0 + 1) check("sig0_step", 96'(sig0), 96'(m_part[c-1]));
            if (done0 && at0 == 0) at0 = c;
            if (done1 && at1 == 0) at1 = c;
        end
        check("done0_latency", 96'(at0), 96'(NV0 + 0 + 2));
        check("done1_latency", 96'(at1), 96'(NV1 + 2 + 2));
        check("sig0_final", 96'(sig0), 96'(m_part[NV0]));
        check("sig1_final", 96'(sig1), 96'(m_part[NV1]));
        check("pass0", 96'(pass0), 96'(ep0));
        check("pass1", 96'(pass1), 96'(ep1));
        check("vec_cnt0", 96'(vc0), 96'(NV0));
        check("vec_cnt1", 96'(vc1), 96'(NV1));
        check("busy0_done", 96'(busy0), 96'(0));
        check("busy1_done", 96'(busy1), 96'(0));
`ifdef EXPR_BIST_MISMATCH_CNT_EN
        check("mis_cnt0", 96'(mc0), 96'((bad0 < NV0) ? 1 : 0));
        check("mis_cnt1", 96'(mc1), 96'((bad1 < NV1) ? 1 : 0));
        check("first_bad0", 96'(fb0), 96'((bad0 < NV0) ? bad0 : 0));
        check("first_bad1", 96'(fb1), 96'((bad1 < NV1) ? bad1 : 0));
`endif
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        seed_in = '0;
        exp0    = '0;
        exp1    = '0;
        dp_k    = 0;
`ifdef EXPR_BIST_MISMATCH_CNT_EN
        gold0 = '0;
        gold1 = '0;
        bad0  = NV0;
        bad1  = NV1;
`endif
        repeat (3) @(negedge clk);
        check("rst_opnd", 96'(opnd0), 96'(0));
        check("rst_busy", 96'(busy0), 96'(0));
        check("rst_done", 96'(done0), 96'(0));
        check("rst_pass", 96'(pass0), 96'(0));
        check("rst_sig", 96'(sig0), 96'(0));
        check("rst_vec_cnt", 96'(vc0), 96'(0));
        rst = 1'b0;

        // Directed: seed 1, identity datapath, matching and non-matching golden signature
        run(60'd1, 0, 1'b0, 1'b0, 1'b0);
        check("sig0_const4", 96'(sig0), 96'(4));
        run(60'd1, 0, 1'b0, 1'b1, 1'b1);
        check("sig0_const4_bad", 96'(sig0), 96'(4));
        // Zero seed behaves like seed 1
        run(60'd0, 0, 1'b0, 1'b0, 1'b0);
        check("sig0_seed0", 96'(sig0), 96'(4));
        // start pulse mid-run is ignored
        run(60'd1, 0, 1'b1, 1'b0, 1'b0);

        // Async reset in the middle of a run
        @(negedge clk);
        seed_in = 60'h123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_vec_cnt", 96'(vc0), 96'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_opnd0", 96'(opnd0), 96'(0));
        check("mid_rst_busy0", 96'(busy0), 96'(0));
        check("mid_rst_vec0", 96'(vc0), 96'(0));
        check("mid_rst_sig0", 96'(sig0), 96'(0));
        check("mid_rst_busy1", 96'(busy1), 96'(0));
        check("mid_rst_opnd1", 96'(opnd1), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        run(60'h123, 3, 1'b0, 1'b0, 1'b0);

`ifdef EXPR_BIST_MISMATCH_CNT_EN
        // Golden data differs on vector 1 only: signature matches but pass must drop
        bad0 = 1;
        bad1 = 1;
        run(60'd1, 0, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            logic [59:0] s;
            s = {$urandom(), $urandom()} & 60'hFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(7) == 0) s = '0;
`ifdef EXPR_BIST_MISMATCH_CNT_EN
            bad0 = $urandom_range(NV0);
            bad1 = $urandom_range(NV1);
`endif
            run(s, $urandom_range(30), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/expr_bist_sched.md
Name: expr_bist_sched

Overview:
- Built-in self-test sequencer for one combinational expression datapath: a 60-bit operand bundle {a0..a5,b0..b5} in, a 90-bit result y out.
- Generates NUM_VECTORS pseudo-random operand vectors from an LFSR and drives them onto the datapath operand bus.
- Compresses each returned result into a 90-bit MISR signature, then compares it against an expected value.
- Sits between the test/config host and the expression datapath instance.

Parameters:
NUM_VECTORS, 256, vectors applied per run (>=1)
LAT, 0, pipeline stages between opnd and res_in (0 = purely combinational datapath)
OPND_W, 60, operand bundle width (fixed by datapath)
RES_W, 90, result width (fixed by datapath)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when in IDLE or DONE
seed_in  in  60  LFSR seed, sampled on accepted start
expected_sig  in  90  golden signature, compared in CHECK
opnd  out  60  operand bundle to datapath
res_in  in  90  datapath result y
busy  out  1  high in RUN/DRAIN/CHECK
done  out  1  high in DONE
pass  out  1  valid while done; 1 = signature matched
signature  out  90  current MISR value
vec_cnt  out  $clog2(NUM_VECTORS+1)  vectors issued so far

Behaviour:
- Reset values: opnd=0, busy=0, done=0, pass=0, signature=0, vec_cnt=0, lfsr=1, valid pipe=0, state=IDLE.
- Async rst forces reset values immediately, including mid-run; no partial result survives.
- LFSR (Fibonacci): next = {lfsr[58:0], lfsr[59]^lfsr[58]}.
  - opnd = lfsr while in RUN; 0 otherwise.
  - seed_in==0 is replaced by 1 to avoid lockup.
- MISR (Galois): next = {misr[88:0],1'b0} ^ (misr[89] ? POLY : 0) ^ res_in, with POLY = 90'h3 | (90'h1<<87).
  - Updates only on cycles where the valid pipe output is 1.
- Valid pipe: LAT-deep shift register fed by the "issue" flag.
  - For LAT=0, res_in is absorbed in the same cycle its opnd is driven.
- States:
  - IDLE: waits for start. On start: lfsr<=seed (fixed), misr<=0, vec_cnt<=0, go RUN.
  - RUN: issue one vector per cycle; lfsr advances; vec_cnt++. When vec_cnt reaches NUM_VECTORS-1 on an issue, go DRAIN (LAT>0) or CHECK (LAT=0).
  - DRAIN: opnd=0, no issue; stay until the valid pipe is empty (exactly LAT cycles), then CHECK.
  - CHECK: one cycle; pass<=(misr==expected_sig); go DONE.
  - DONE: done=1, pass held. start re-arms exactly as from IDLE, with done dropping the next cycle.
- start while busy is ignored; no queueing.
- Total latency start->done: NUM_VECTORS + LAT + 2 cycles.
- vec_cnt saturates at NUM_VECTORS and holds through DONE.

Optional Feature:
- Macro: EXPR_BIST_MISMATCH_CNT_EN.
- Enabled:
  - Adds input gold_in[89:0], output mis_cnt[15:0], and output first_bad[$clog2(NUM_VECTORS)-1:0].
  - On every absorbed result, res_in != gold_in increments mis_cnt, saturating at 16'hFFFF.
  - first_bad latches the index of the first mismatching vector.
  - pass additionally requires mis_cnt==0.
  - All three outputs clear on accepted start and on rst.
- Disabled: ports absent; pass depends on the signature only.

Decomposition:
- Package expr_bist_pkg holds:
  - OPND_W, RES_W constants, LFSR tap indices, MISR POLY;
  - the state enum (IDLE, RUN, DRAIN, CHECK, DONE);
  - function lfsr_next and function misr_next.
- One sub-module, expr_bist_misr: 90-bit register plus next-state logic, with enable and clear.

Test Plan:
- NUM_VECTORS=3, LAT=0, seed=1, res_in={30'b0,opnd}, expected_sig=4 -> opnd 1,2,4 on consecutive cycles; signature 1,0,4; done at cycle 5 after start; pass=1.
- Same run with expected_sig=5 -> pass=0, signature=4.
- seed=0 -> first opnd=1; results identical to the seed=1 run.
- LAT=2, NUM_VECTORS=3, res_in = 2-cycle-delayed {30'b0,opnd} -> two DRAIN cycles; signature=4; done 7 cycles after start.
- rst asserted during RUN at vec_cnt=1 -> all outputs immediately 0 and state IDLE; a subsequent start runs a full, correct sequence. start pulsed mid-RUN -> ignored, vec_cnt unaffected.
- EXPR_BIST_MISMATCH_CNT_EN defined, gold_in differs from res_in on vector 1 only -> mis_cnt=1, first_bad=1, pass=0 despite signature match.
